// File: rtl/mem_stage_if.sv
// Data-memory port between the MEM stage and the memory.
// The master drives req/we/addr/wdata; the slave answers with gnt/rvalid/rdata.
interface mem_stage_if #(
  parameter int DATA_W = 32
);
  logic              d_req;
  logic              d_we;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  modport master (
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata
  );

  modport slave (
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores on a req/gnt/rvalid port, stalls on wait
// states, aborts an access that stays outstanding too long, and feeds forwarding and WB.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] ALU_out_MEM,
  input  logic [DATA_W-1:0] store_data_MEM,
  input  logic              d_write_enable_MEM,
  input  logic              d_load_enable_MEM,
  input  logic [4:0]        Rd_MEM,
  output logic [DATA_W-1:0] ALU_out_MEM_backward,
  output logic [4:0]        Rd_MEM_backward,
  output logic              stall_MEM,
  mem_stage_if.master       dmem,
  output logic [DATA_W-1:0] result_WB,
  output logic [4:0]        Rd_WB,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             is_store, is_load, mem_op, timeout;
  logic             wb_alu, wb_rdata;

  assign is_store = d_write_enable_MEM;
  assign is_load  = d_load_enable_MEM & ~d_write_enable_MEM;
  assign mem_op   = is_store | is_load;

  // cnt holds the number of cycles the access has already been outstanding,
  // so the access is abandoned in its TIMEOUT-th cycle. A late load grant can
  // carry cnt past the limit, hence the >= comparison.
  assign timeout = (cnt >= CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    stall_MEM     = 1'b0;
    bus_err       = 1'b0;
    wb_alu        = 1'b0;
    wb_rdata      = 1'b0;
    dmem.d_req    = 1'b0;
    dmem.d_we     = is_store;
    dmem.d_addr   = ALU_out_MEM;
    dmem.d_wdata  = store_data_MEM;
    case (state)
      IDLE: begin
        if (!mem_op) begin
          wb_alu = 1'b1;
        end else begin
          dmem.d_req = 1'b1;
          if (!(is_store && dmem.d_gnt)) begin
            stall_MEM = 1'b1;
            cnt_nx    = CNT_W'(1);
            state_nx  = dmem.d_gnt ? WAIT_DATA : REQ;
          end
        end
      end
      REQ: begin
        dmem.d_req = 1'b1;
        if (dmem.d_gnt && is_store) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (dmem.d_gnt) begin
          stall_MEM = 1'b1;
          state_nx  = WAIT_DATA;
          cnt_nx    = cnt + CNT_W'(1);
        end else if (timeout) begin
          bus_err  = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          stall_MEM = 1'b1;
          cnt_nx    = cnt + CNT_W'(1);
        end
      end
      WAIT_DATA: begin
        if (dmem.d_rvalid) begin
          wb_rdata = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (timeout) begin
          bus_err  = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          stall_MEM = 1'b1;
          cnt_nx    = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      result_WB <= '0;
      Rd_WB     <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (wb_alu) begin
        result_WB <= ALU_out_MEM;
        Rd_WB     <= Rd_MEM;
      end else if (wb_rdata) begin
        result_WB <= dmem.d_rdata;
        Rd_WB     <= Rd_MEM;
      end else begin
        Rd_WB <= '0;
      end
    end
  end

  // Loads never forward: their data is not known here, the stall covers the hazard.
  assign Rd_MEM_backward      = (is_load || Rd_MEM == 5'd0) ? 5'd0 : Rd_MEM;
  assign ALU_out_MEM_backward = (is_load || Rd_MEM == 5'd0) ? '0 : ALU_out_MEM;

endmodule
